// File: rtl/freq_channel_scheduler_pkg.sv
// Shared types and constants for the frequency channel scheduler.
//   freq_sched_state_t : scheduler FSM state encoding
//   STABLE_CONFIRM     : consecutive stable samples required before a capture
package freq_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StSettle,
    StWaitStable,
    StCapture,
    StOutput,
    StNext
  } freq_sched_state_t;

  localparam int unsigned STABLE_CONFIRM = 2;

endpackage

// File: rtl/freq_channel_scheduler_if.sv
// Result stream between the scheduler and the result consumer.
//   res_valid   : result valid (source -> sink)
//   res_ready   : consumer ready (sink -> source)
//   res_ch      : channel the result belongs to
//   res_period  : captured period word, 0 on timeout
//   res_timeout : result is a timeout
// Modports: master = scheduler side, slave = consumer side.
interface freq_channel_scheduler_if #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned COUNTER_WIDTH = 18
);

  localparam int unsigned ChW = $clog2(NUM_CH);

  logic                     res_valid;
  logic                     res_ready;
  logic [ChW-1:0]           res_ch;
  logic [COUNTER_WIDTH-1:0] res_period;
  logic                     res_timeout;

  modport master (
    output res_valid,
    output res_ch,
    output res_period,
    output res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_ch,
    input  res_period,
    input  res_timeout,
    output res_ready
  );

endinterface

// File: rtl/freq_channel_scheduler_rr_next_ch.sv
// Combinational round-robin channel picker.
//   mask            : per-channel enable mask
//   cur             : current channel index
//   include_current : 1 = search starts at cur, 0 = search starts after cur
//   next            : first enabled channel found (cur when none)
//   found           : mask has at least one enabled channel
module rr_next_ch #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned ChW    = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [ChW-1:0]    cur,
  input  logic              include_current,
  output logic [ChW-1:0]    next,
  output logic              found
);

  localparam int unsigned StartW = ChW + 1;

  logic [StartW-1:0]   start;
  logic [2*NUM_CH-1:0] dbl_mask;
  logic [2*NUM_CH-1:0] rot_full;
  logic [NUM_CH-1:0]   rot;

  // start may equal NUM_CH when cur is the last channel and cur is excluded;
  // the doubled mask makes that wrap to channel 0 without a modulo.
  assign start    = {1'b0, cur} + StartW'(!include_current);
  assign dbl_mask = {mask, mask};
  assign rot_full = dbl_mask >> start;
  assign rot      = rot_full[NUM_CH-1:0];

  always_comb begin
    int unsigned sum;
    sum   = 0;
    next  = cur;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = 32'(start) + i;
        if (sum >= NUM_CH) begin
          sum = sum - NUM_CH;
        end
        next = ChW'(sum);
      end
    end
  end

endmodule

// File: rtl/freq_channel_scheduler.sv
// Shares one period-measurement detector among NUM_CH comparator channels.
// Round-robins over enabled channels: selects the mux input, clears the
// detector, lets it settle, waits for a confirmed stable reading (or a
// timeout) and hands the result to the consumer over a valid/ready stream.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   run         : scanning continues while high
//   ch_enable   : per-channel enable mask
//   ch_sel      : input mux select (registered)
//   det_rst_n   : detector reset, active-low (registered)
//   det_period  : detector averaged period (lags det_stable by one cycle)
//   det_stable  : detector stable flag
//   res         : result stream (master modport)
//   busy        : FSM not idle
//
// Build option: FREQ_SCHED_TIMEOUT_EN adds the per-channel timeout counter.
// Without it WAIT_STABLE waits indefinitely and res_timeout is constant 0.
module freq_channel_scheduler
  import freq_sched_pkg::*;
#(
  parameter  int unsigned NUM_CH         = 4,
  parameter  int unsigned COUNTER_WIDTH  = 18,
  parameter  int unsigned DET_CLR_CYCLES = 2,
  parameter  int unsigned SETTLE_CYCLES  = 16,
  parameter  int unsigned TIMEOUT_CYCLES = 4_000_000,
  localparam int unsigned ChW            = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [ChW-1:0]           ch_sel,
  output logic                     det_rst_n,
  input  logic [COUNTER_WIDTH-1:0] det_period,
  input  logic                     det_stable,
  freq_channel_scheduler_if.master res,
  output logic                     busy
);

  localparam int unsigned PhMax = (DET_CLR_CYCLES > SETTLE_CYCLES) ? DET_CLR_CYCLES
                                                                   : SETTLE_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);
  localparam int unsigned StW   = $clog2(STABLE_CONFIRM + 1);

  freq_sched_state_t        state_q;
  logic [ChW-1:0]           ch_sel_q;
  logic                     det_rst_n_q;
  logic                     busy_q;
  logic                     res_valid_q;
  logic [ChW-1:0]           res_ch_q;
  logic [COUNTER_WIDTH-1:0] res_period_q;
  logic [PhW-1:0]           phase_q;
  logic [StW-1:0]           stable_cnt_q;

`ifdef FREQ_SCHED_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
  logic                     res_timeout_q;
  logic [WaitW-1:0]         wait_cnt_q;
`endif

  logic [ChW-1:0] rr_next;
  logic           rr_found;
  logic           stable_hit;

  // IDLE may restart on the current channel; NEXT always moves past it.
  rr_next_ch #(
    .NUM_CH(NUM_CH)
  ) u_rr_next_ch (
    .mask           (ch_enable),
    .cur            (ch_sel_q),
    .include_current(state_q == StIdle),
    .next           (rr_next),
    .found          (rr_found)
  );

  assign stable_hit = det_stable && (stable_cnt_q == StW'(STABLE_CONFIRM - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ch_sel_q      <= '0;
      det_rst_n_q   <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_period_q  <= '0;
      phase_q       <= '0;
      stable_cnt_q  <= '0;
`ifdef FREQ_SCHED_TIMEOUT_EN
      res_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          det_rst_n_q <= 1'b0;
          busy_q      <= 1'b0;
          if (run && rr_found) begin
            ch_sel_q <= rr_next;
            phase_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= StSelect;
          end
        end
        StSelect: begin
          if (phase_q == PhW'(DET_CLR_CYCLES - 1)) begin
            phase_q     <= '0;
            det_rst_n_q <= 1'b1;
            state_q     <= StSettle;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StSettle: begin
          if (phase_q == PhW'(SETTLE_CYCLES - 1)) begin
            phase_q      <= '0;
            stable_cnt_q <= '0;
`ifdef FREQ_SCHED_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
            state_q      <= StWaitStable;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StWaitStable: begin
          if (stable_hit) begin
            state_q <= StCapture;
`ifdef FREQ_SCHED_TIMEOUT_EN
          end else if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES)) begin
            res_valid_q   <= 1'b1;
            res_ch_q      <= ch_sel_q;
            res_period_q  <= '0;
            res_timeout_q <= 1'b1;
            state_q       <= StOutput;
`endif
          end else begin
            stable_cnt_q <= det_stable ? stable_cnt_q + 1'b1 : '0;
`ifdef FREQ_SCHED_TIMEOUT_EN
            // Leaving on equality means the counter can never pass the limit.
            wait_cnt_q   <= wait_cnt_q + 1'b1;
`endif
          end
        end
        StCapture: begin
          // Period word lags stable, so it is taken one cycle after the confirm.
          res_valid_q   <= 1'b1;
          res_ch_q      <= ch_sel_q;
          res_period_q  <= det_period;
`ifdef FREQ_SCHED_TIMEOUT_EN
          res_timeout_q <= 1'b0;
`endif
          state_q       <= StOutput;
        end
        StOutput: begin
          if (res.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StNext;
          end
        end
        StNext: begin
          det_rst_n_q <= 1'b0;
          if (run && rr_found) begin
            ch_sel_q <= rr_next;
            phase_q  <= '0;
            state_q  <= StSelect;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ch_sel         = ch_sel_q;
  assign det_rst_n      = det_rst_n_q;
  assign busy           = busy_q;
  assign res.res_valid  = res_valid_q;
  assign res.res_ch     = res_ch_q;
  assign res.res_period = res_period_q;
`ifdef FREQ_SCHED_TIMEOUT_EN
  assign res.res_timeout = res_timeout_q;
`else
  assign res.res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_freq_channel_scheduler.sv
// Self-checking bench for freq_channel_scheduler: behavioural detector with
// per-channel period and stable-after delay, and a result-sequence model
// derived from the round-robin rules.
module tb_freq_channel_scheduler;

  localparam int unsigned NCh  = 4;
  localparam int unsigned CW   = 18;
  localparam int unsigned DCLR = 2;
  localparam int unsigned SET  = 4;
  localparam int unsigned TO   = 1000;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic [NCh-1:0]  ch_enable;
  logic [1:0]      ch_sel;
  logic            det_rst_n;
  logic [CW-1:0]   det_period;
  logic            det_stable;
  logic            busy;

  freq_channel_scheduler_if #(.NUM_CH(NCh), .COUNTER_WIDTH(CW)) res_if ();

  freq_channel_scheduler #(
    .NUM_CH        (NCh),
    .COUNTER_WIDTH (CW),
    .DET_CLR_CYCLES(DCLR),
    .SETTLE_CYCLES (SET),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .ch_enable (ch_enable),
    .ch_sel    (ch_sel),
    .det_rst_n (det_rst_n),
    .det_period(det_period),
    .det_stable(det_stable),
    .res       (res_if),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Detector model: stable stable_after[ch] cycles after release (<0: never),
  // period word valid one cycle after stable, junk before that.
  int            stable_after [NCh];
  logic [CW-1:0] period_tab   [NCh];
  int            det_cnt = 0;

  always @(posedge clk) begin
    if (!det_rst_n) det_cnt <= 0;
    else if (det_cnt < 1000000) det_cnt <= det_cnt + 1;
  end

  assign det_stable = det_rst_n && (stable_after[ch_sel] >= 0) &&
                      (det_cnt >= stable_after[ch_sel]);

  always @(posedge clk) det_period <= det_stable ? period_tab[ch_sel] : CW'($urandom);

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [NCh-1:0] m_mask;
  logic [1:0]     m_next;
  logic [1:0]     m_last = 2'd0;
  bit             rnd_ready = 1'b0;
  int             bad_sel = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First enabled channel at (incl) or strictly after (!incl) cur, wrapping.
  function automatic logic [1:0] pick(input logic [NCh-1:0] mask, input logic [1:0] cur,
                                      input bit incl);
    for (int k = 0; k < NCh; k++) begin
      int c;
      c = (int'(cur) + (incl ? k : k + 1)) % NCh;
      if (mask[c[1:0]]) return c[1:0];
    end
    return cur;
  endfunction

  task automatic check_reset(input string pfx);
    check({pfx, "_ch_sel"},      64'(ch_sel),             64'(0));
    check({pfx, "_det_rst_n"},   64'(det_rst_n),          64'(0));
    check({pfx, "_res_valid"},   64'(res_if.res_valid),   64'(0));
    check({pfx, "_res_ch"},      64'(res_if.res_ch),      64'(0));
    check({pfx, "_res_period"},  64'(res_if.res_period),  64'(0));
    check({pfx, "_res_timeout"}, 64'(res_if.res_timeout), 64'(0));
    check({pfx, "_busy"},        64'(busy),               64'(0));
  endtask

  // One cycle: drive ready, and check any transfer against the model.
  task automatic step_xfer(output bit got);
    bit to_exp;
    @(negedge clk);
    res_if.res_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
    if (busy && !m_mask[ch_sel]) bad_sel++;
    got = 1'b0;
    if (res_if.res_valid && res_if.res_ready) begin
      got    = 1'b1;
      to_exp = stable_after[m_next] < 0;
      check("xfer_ch",      64'(res_if.res_ch),      64'(m_next));
      check("xfer_timeout", 64'(res_if.res_timeout), 64'(to_exp));
      check("xfer_period",  64'(res_if.res_period),  to_exp ? 64'(0) : 64'(period_tab[m_next]));
      m_last = m_next;
      m_next = pick(m_mask, m_next, 1'b0);
    end
  endtask

  task automatic expect_n(input int n, input int budget);
    int got_n = 0;
    int cyc   = 0;
    bit got;
    while (got_n < n && cyc < budget) begin
      step_xfer(got);
      if (got) got_n++;
      cyc++;
    end
    check("xfer_count", 64'(got_n), 64'(n));
  endtask

  // Drop run and let the in-flight channel finish; returns delivered count.
  task automatic drain(input int budget, output int delivered);
    int cyc = 0;
    bit got;
    delivered = 0;
    run = 1'b0;
    do begin
      step_xfer(got);
      if (got) delivered++;
      cyc++;
    end while (busy && cyc < budget);
    check("drain_busy",      64'(busy),      64'(0));
    check("drain_det_rst_n", 64'(det_rst_n), 64'(0));
  endtask

  task automatic wait_busy(input int budget);
    int cyc = 0;
    while (!busy && cyc < budget) begin @(negedge clk); cyc++; end
    check("busy_rise", 64'(busy), 64'(1));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int cyc = 0;
    while (!res_if.res_valid && cyc < budget) begin @(negedge clk); cyc++; end
    check(tag, 64'(res_if.res_valid), 64'(1));
  endtask

  initial begin
    int             lat;
    int             diff;
    int             cnt;
    int             dlv;
    logic [1:0]     h_ch;
    logic [CW-1:0]  h_per;
    logic           h_to;

    rst = 1'b1; run = 1'b0; ch_enable = '0; res_if.res_ready = 1'b1;
    for (int i = 0; i < NCh; i++) begin stable_after[i] = 5; period_tab[i] = CW'(100 + i); end
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // 1: two enabled channels alternate.
    period_tab[0] = 18'd200; period_tab[2] = 18'd500;
    stable_after[0] = 3; stable_after[2] = 7;
    m_mask = 4'b0101; ch_enable = m_mask; m_next = pick(m_mask, m_last, 1'b1);
    bad_sel = 0; run = 1'b1;
    expect_n(3, 300);
    drain(300, dlv);
    check("t1_bad_sel", 64'(bad_sel), 64'(0));

    // 2: never-stable channel.
    stable_after[1] = -1;
    m_mask = 4'b0010; ch_enable = m_mask; m_next = pick(m_mask, m_last, 1'b1);
    res_if.res_ready = 1'b0; run = 1'b1;
`ifdef FREQ_SCHED_TIMEOUT_EN
    wait_busy(20);
    lat = 0;
    while (!res_if.res_valid && lat < 2000) begin @(negedge clk); lat++; end
    check("t2_latency",  64'(lat),                 64'(DCLR + SET + TO + 1));
    check("t2_res_ch",   64'(res_if.res_ch),       64'(1));
    check("t2_timeout",  64'(res_if.res_timeout),  64'(1));
    check("t2_period",   64'(res_if.res_period),   64'(0));
    drain(100, dlv);
    check("t2_delivered", 64'(dlv), 64'(1));
`else
    cnt = 0;
    repeat (5000) begin @(negedge clk); if (res_if.res_valid) cnt++; end
    check("t2_no_result", 64'(cnt),  64'(0));
    check("t2_busy",      64'(busy), 64'(1));
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0; m_last = 2'd0;
`endif
    stable_after[1] = 5;

    // 3: backpressure for 50 cycles.
    m_mask = 4'b0001; ch_enable = m_mask; stable_after[0] = 3; period_tab[0] = 18'd200;
    res_if.res_ready = 1'b0; run = 1'b1;
    wait_valid("t3_valid", 300);
    h_ch = res_if.res_ch; h_per = res_if.res_period; h_to = res_if.res_timeout;
    check("t3_ch",     64'(h_ch),  64'(0));
    check("t3_period", 64'(h_per), 64'(200));
    diff = 0;
    repeat (50) begin
      @(negedge clk);
      if (!res_if.res_valid || res_if.res_ch !== h_ch || res_if.res_period !== h_per ||
          res_if.res_timeout !== h_to) diff++;
    end
    check("t3_hold", 64'(diff), 64'(0));
    res_if.res_ready = 1'b1;
    @(negedge clk);
    check("t3_one_xfer", 64'(res_if.res_valid), 64'(0));
    @(negedge clk);
    check("t3_next_det_rst_n", 64'(det_rst_n), 64'(0));
    check("t3_next_busy",      64'(busy),      64'(1));
    check("t3_next_ch_sel",    64'(ch_sel),    64'(0));
    m_last = 2'd0; m_next = 2'd0;
    drain(300, dlv);

    // 4: run dropped during WAIT_STABLE still delivers the channel.
    m_mask = 4'b0100; ch_enable = m_mask; stable_after[2] = 30; period_tab[2] = 18'd500;
    m_next = pick(m_mask, m_last, 1'b1); run = 1'b1;
    wait_busy(20);
    repeat (DCLR + SET + 5) @(negedge clk);
    check("t4_in_wait_det", 64'(det_rst_n),        64'(1));
    check("t4_in_wait_val", 64'(res_if.res_valid), 64'(0));
    drain(400, dlv);
    check("t4_delivered", 64'(dlv), 64'(1));

    // 5: reset during OUTPUT drops the result.
    m_mask = 4'b0001; ch_enable = m_mask; res_if.res_ready = 1'b0; run = 1'b1;
    wait_valid("t5_valid", 300);
    rst = 1'b1; res_if.res_ready = 1'b1; run = 1'b0;
    @(negedge clk);
    check_reset("t5");
    rst = 1'b0; m_last = 2'd0;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (res_if.res_valid) cnt++; end
    check("t5_no_xfer", 64'(cnt), 64'(0));

    // 6: empty mask keeps IDLE; then a single channel starts immediately.
    ch_enable = 4'b0000; run = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (busy || det_rst_n) cnt++; end
    check("t6_idle", 64'(cnt), 64'(0));
    ch_enable = 4'b1000;
    @(negedge clk);
    check("t6_ch_sel",    64'(ch_sel),    64'(3));
    check("t6_busy",      64'(busy),      64'(1));
    check("t6_det_rst_n", 64'(det_rst_n), 64'(0));
    m_mask = 4'b1000; m_next = 2'd3;
    drain(300, dlv);

    // Randomized rounds: random mask, periods, stable delays and backpressure.
    rnd_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      m_mask = NCh'($urandom_range(1, 15));
      for (int i = 0; i < NCh; i++) begin
        period_tab[i]   = CW'($urandom_range(1, 262143));
        stable_after[i] = int'($urandom_range(0, 20));
`ifdef FREQ_SCHED_TIMEOUT_EN
        if ($urandom_range(9) == 0) stable_after[i] = -1;
`endif
      end
      ch_enable = m_mask; m_next = pick(m_mask, m_last, 1'b1);
      bad_sel = 0; run = 1'b1;
      expect_n(5, 6000);
      drain(3000, dlv);
      check("rnd_bad_sel", 64'(bad_sel), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/freq_channel_scheduler.md
# freq_channel_scheduler

Sequencer that shares a single square-wave period-measurement engine (the comparator-fed frequency detector) among `NUM_CH` comparator channels. It round-robins over enabled channels and drives the input mux select. For each channel it clears the detector, waits for a stable reading or a timeout, then presents the result on a valid/ready stream. It sits between the comparator input mux and the result consumer (host register bank or display logic).

## Interface
- `NUM_CH`, default 4: number of comparator channels, 2..16.
- `COUNTER_WIDTH`, default 18: width of the detector period word.
- `DET_CLR_CYCLES`, default 2: cycles the detector reset is held low on a channel switch.
- `SETTLE_CYCLES`, default 16: cycles after the detector is released before stable is monitored.
- `TIMEOUT_CYCLES`, default 4_000_000: maximum wait for stable per channel (20 ms at 200 MHz).
- `clk` in, 1: system clock.
- `rst` in, 1: reset, synchronous, active-high.
- `run` in, 1: level; scanning continues while high.
- `ch_enable` in, NUM_CH: per-channel enable mask.
- `ch_sel` out, $clog2(NUM_CH): input mux select, registered.
- `det_rst_n` out, 1: detector reset, registered, active-low.
- `det_period` in, COUNTER_WIDTH: detector averaged period.
- `det_stable` in, 1: detector stable flag.
- `res_valid` out, 1: result valid.
- `res_ready` in, 1: consumer ready.
- `res_ch` out, $clog2(NUM_CH): channel of the result.
- `res_period` out, COUNTER_WIDTH: captured period; 0 on timeout.
- `res_timeout` out, 1: the result is a timeout.
- `busy` out, 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, SELECT, SETTLE, WAIT_STABLE, CAPTURE, OUTPUT, NEXT.
- **IDLE**
  - `det_rst_n`=0 and `busy`=0.
  - If `run`=1 and `ch_enable`≠0: load `ch_sel` with the first enabled channel at or after the current `ch_sel` (wrapping), then go to SELECT.
- **SELECT**
  - `det_rst_n`=0 for exactly DET_CLR_CYCLES cycles, then SETTLE.
- **SETTLE**
  - `det_rst_n`=1 for SETTLE_CYCLES cycles, then WAIT_STABLE.
- **WAIT_STABLE**
  - Go to CAPTURE when `det_stable` is sampled high on 2 consecutive cycles. The detector's period word lags stable by one cycle.
  - Go to OUTPUT with `res_timeout`=1 and `res_period`=0 when the wait counter reaches TIMEOUT_CYCLES.
- **CAPTURE**
  - One cycle: latch `res_period`=`det_period`, `res_ch`=`ch_sel`, `res_timeout`=0.
- **OUTPUT**
  - `res_valid`=1; `res_*` held constant until a cycle with `res_valid`&&`res_ready`, then NEXT.
  - If `res_ready` is high on entry, the transfer occurs on the first OUTPUT cycle.
- **NEXT**
  - One cycle: sample `run` and `ch_enable`.
  - If `run`=0 or mask=0, go to IDLE.
  - Otherwise `ch_sel` becomes the next enabled channel strictly after the current one, wrapping NUM_CH-1 to 0; go to SELECT.
  - With a single enabled channel, that channel is re-measured.
- `ch_enable` and `run` changes mid-measurement do not abort it; the current channel completes and is delivered.
- Wait counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to WAIT_STABLE and saturates, never wrapping.

## Timing
- Reset values: `ch_sel`=0, `det_rst_n`=0, `res_valid`=0, `res_ch`=0, `res_period`=0, `res_timeout`=0, `busy`=0, state IDLE.
- `rst` asserted mid-operation returns to reset values on the next edge. Any pending result is dropped.
- All outputs are registered; no combinational path from inputs to outputs.
- `run` rising in IDLE: `busy`=1 and `det_rst_n`=0 (SELECT) from the next cycle.
- Minimum channel latency, SELECT entry to `res_valid`: DET_CLR_CYCLES + SETTLE_CYCLES + (cycles to stable) + 2 + 1.
- Timeout latency, SELECT entry to `res_valid`: DET_CLR_CYCLES + SETTLE_CYCLES + TIMEOUT_CYCLES + 1.
- `ch_sel` changes only on the NEXT→SELECT and IDLE→SELECT transitions, while `det_rst_n`=0.

## Configuration
- `FREQ_SCHED_TIMEOUT_EN` defined: timeout counter present; behaviour as above.
- Not defined:
  - No counter is built; WAIT_STABLE waits indefinitely for stable.
  - `res_timeout` is tied to 0; `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `freq_sched_pkg` holds:
  - the state enum `freq_sched_state_t`;
  - the constant `STABLE_CONFIRM = 2`.
- Sub-module `rr_next_ch` is combinational. Inputs are mask, current index and an `include_current` flag; outputs are next index and `found`. It is used by both IDLE and NEXT.

## Test plan
Bench parameters: NUM_CH=4, DET_CLR_CYCLES=2, SETTLE_CYCLES=4, TIMEOUT_CYCLES=1000. The detector is a behavioural model with per-channel period and stable-after delay.

1. `ch_enable`=4'b0101, `run`=1, ch0 period 200, ch2 period 500, `res_ready`=1 → results alternate (ch0,200),(ch2,500),(ch0,200); ch1/ch3 never on `ch_sel`.
2. ch1 never stable, `ch_enable`=4'b0010 → `res_valid` with `res_ch`=1, `res_timeout`=1, `res_period`=0, exactly 2+4+1000+1 cycles after SELECT entry. With the macro undefined → no result after 5000 cycles.
3. `res_ready` held 0 for 50 cycles on a result → `res_*` unchanged across all 50 cycles; exactly one transfer; the next channel starts afterwards.
4. `run` dropped during WAIT_STABLE of ch2 → ch2 result still delivered; then IDLE, `busy`=0, `det_rst_n`=0.
5. `rst` pulsed for 1 cycle during OUTPUT → next cycle all outputs at reset values; no transfer.
6. `ch_enable`=0 with `run`=1 → FSM stays in IDLE, `busy`=0. Set mask 4'b1000 → `ch_sel`=3 and SELECT on the next cycle.
